// File: rtl/leonel_irq_pkg.sv
// Shared types and default sizing for the interrupt / flag-shadow controller.
package leonel_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VECTOR  = 2'd1,
        ISR     = 2'd2,
        RESTORE = 2'd3
    } irq_state_t;

    localparam int          PC_W_DEF     = 10;
    localparam int          N_IRQ_DEF    = 4;
    localparam logic [9:0]  VEC_BASE_DEF = 10'h3F0;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered active line wins.
module irq_prio_enc #(
    parameter int N_IRQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_IRQ-1:0] pend,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |pend;
        idx   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_flag_ctrl.sv
// Interrupt entry/exit controller: shadows return PC and C/Z flags on entry,
// and restores them through the flag register's interrupt write port on RETI.
module irq_flag_ctrl
    import leonel_irq_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              N_IRQ    = N_IRQ_DEF,
    parameter logic [PC_W-1:0] VEC_BASE = PC_W'(VEC_BASE_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clock_en,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic             gie_we_i,
    input  logic             gie_i,
    input  logic             instr_done_i,
    input  logic             reti_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             c_i,
    input  logic             z_i,
    output logic             pc_load_o,
    output logic [PC_W-1:0]  pc_load_val_o,
    output logic             iwe_o,
    output logic             intc_o,
    output logic             intz_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             in_isr_o,
    output logic             gie_o
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t        r_state;
    logic              r_gie;
    logic [IDX_W-1:0]  r_idx;
    logic [PC_W-1:0]   r_sh_pc;
    logic              r_sh_c;
    logic              r_sh_z;

    logic [N_IRQ-1:0]  w_pend;
    logic              w_pend_vld;
    logic [IDX_W-1:0]  w_pend_idx;
    logic              w_take;

    assign w_pend = irq_i & irq_mask_i;

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .pend  (w_pend),
        .valid (w_pend_vld),
        .idx   (w_pend_idx)
    );

    // Acceptance looks at the pre-edge GIE, so a same-cycle EI cannot admit a request.
    assign w_take = instr_done_i && r_gie && w_pend_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gie   <= 1'b0;
            r_idx   <= '0;
            r_sh_pc <= '0;
            r_sh_c  <= 1'b0;
            r_sh_z  <= 1'b0;
        end else if (clock_en) begin
            if (gie_we_i) begin
                r_gie <= gie_i;
            end
            // State-driven GIE updates follow the EI/DI write so they take precedence.
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_sh_pc <= pc_i;
                        r_sh_c  <= c_i;
                        r_sh_z  <= z_i;
                        r_idx   <= w_pend_idx;
                        r_state <= VECTOR;
                    end
                end
                VECTOR: begin
                    r_gie   <= 1'b0;
                    r_state <= ISR;
                end
                ISR: begin
                    if (instr_done_i && reti_i) begin
                        r_state <= RESTORE;
                    end
                end
                RESTORE: begin
                    r_gie   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, so they hold steady across clock_en stalls.
    always_comb begin
        pc_load_o     = 1'b0;
        pc_load_val_o = '0;
        iwe_o         = 1'b0;
        intc_o        = 1'b0;
        intz_o        = 1'b0;
        irq_ack_o     = '0;
        in_isr_o      = 1'b0;
        case (r_state)
            VECTOR: begin
                pc_load_o     = 1'b1;
                pc_load_val_o = VEC_BASE + PC_W'(r_idx);
                irq_ack_o     = N_IRQ'(1) << r_idx;
            end
            ISR: begin
                in_isr_o = 1'b1;
            end
            RESTORE: begin
                pc_load_o     = 1'b1;
                pc_load_val_o = r_sh_pc;
                iwe_o         = 1'b1;
                intc_o        = r_sh_c;
                intz_o        = r_sh_z;
            end
            default: ;
        endcase
    end

    assign gie_o = r_gie;

endmodule

// File: tb/tb_irq_flag_ctrl.sv
// Directed bench for irq_flag_ctrl with hand-computed expected values.
module tb_irq_flag_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clock_en;
    logic [3:0] irq_i;
    logic [3:0] irq_mask_i;
    logic       gie_we_i;
    logic       gie_i;
    logic       instr_done_i;
    logic       reti_i;
    logic [9:0] pc_i;
    logic       c_i;
    logic       z_i;
    logic       pc_load_o;
    logic [9:0] pc_load_val_o;
    logic       iwe_o;
    logic       intc_o;
    logic       intz_o;
    logic [3:0] irq_ack_o;
    logic       in_isr_o;
    logic       gie_o;

    int n_chk = 0;
    int n_err = 0;

    irq_flag_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .clock_en      (clock_en),
        .irq_i         (irq_i),
        .irq_mask_i    (irq_mask_i),
        .gie_we_i      (gie_we_i),
        .gie_i         (gie_i),
        .instr_done_i  (instr_done_i),
        .reti_i        (reti_i),
        .pc_i          (pc_i),
        .c_i           (c_i),
        .z_i           (z_i),
        .pc_load_o     (pc_load_o),
        .pc_load_val_o (pc_load_val_o),
        .iwe_o         (iwe_o),
        .intc_o        (intc_o),
        .intz_o        (intz_o),
        .irq_ack_o     (irq_ack_o),
        .in_isr_o      (in_isr_o),
        .gie_o         (gie_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Walk from VECTOR through ISR and RESTORE back to IDLE.
    task automatic finish_isr();
        instr_done_i = 1'b0; reti_i = 1'b0;
        cyc();
        instr_done_i = 1'b1; reti_i = 1'b1;
        cyc();
        instr_done_i = 1'b0; reti_i = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b0; clock_en = 1'b1; irq_i = 4'hF; irq_mask_i = 4'hF;
        gie_we_i = 1'b0; gie_i = 1'b0; instr_done_i = 1'b1; reti_i = 1'b1;
        pc_i = 10'h000; c_i = 1'b0; z_i = 1'b0;

        cyc(); cyc();
        chk("rst_pc_load", 32'(pc_load_o), 32'h0);
        chk("rst_pc_val",  32'(pc_load_val_o), 32'h0);
        chk("rst_iwe",     32'(iwe_o), 32'h0);
        chk("rst_ack",     32'(irq_ack_o), 32'h0);
        chk("rst_in_isr",  32'(in_isr_o), 32'h0);
        chk("rst_gie",     32'(gie_o), 32'h0);

        reti_i = 1'b0;
        rst = 1'b1;
        cyc();
        chk("post_rst_no_vec", 32'(pc_load_o), 32'h0);
        chk("post_rst_gie",    32'(gie_o), 32'h0);

        // EI on the same edge as a request: old GIE=0 blocks it.
        irq_i = 4'b0100; gie_we_i = 1'b1; gie_i = 1'b1;
        cyc();
        chk("ei_same_edge_no_vec", 32'(pc_load_o), 32'h0);
        chk("ei_gie",              32'(gie_o), 32'h1);

        gie_we_i = 1'b0; pc_i = 10'h025; c_i = 1'b1; z_i = 1'b0;
        cyc();
        chk("entry_pc_load", 32'(pc_load_o), 32'h1);
        chk("entry_vec",     32'(pc_load_val_o), 32'h3F2);
        chk("entry_ack",     32'(irq_ack_o), 32'h4);

        // Dropping the request after acceptance changes nothing.
        instr_done_i = 1'b0; irq_i = 4'b0000;
        cyc();
        chk("isr_in_isr",  32'(in_isr_o), 32'h1);
        chk("isr_pc_load", 32'(pc_load_o), 32'h0);
        chk("isr_ack",     32'(irq_ack_o), 32'h0);
        chk("isr_gie",     32'(gie_o), 32'h0);

        irq_i = 4'b0001; instr_done_i = 1'b1;
        cyc();
        chk("nonest_pc_load", 32'(pc_load_o), 32'h0);
        chk("nonest_in_isr",  32'(in_isr_o), 32'h1);

        reti_i = 1'b1; pc_i = 10'h3AA; c_i = 1'b0; z_i = 1'b1;
        cyc();
        chk("restore_pc_load", 32'(pc_load_o), 32'h1);
        chk("restore_val",     32'(pc_load_val_o), 32'h025);
        chk("restore_iwe",     32'(iwe_o), 32'h1);
        chk("restore_intc",    32'(intc_o), 32'h1);
        chk("restore_intz",    32'(intz_o), 32'h0);

        reti_i = 1'b0; instr_done_i = 1'b0;
        cyc();
        chk("exit_gie",     32'(gie_o), 32'h1);
        chk("exit_iwe",     32'(iwe_o), 32'h0);
        chk("exit_pc_load", 32'(pc_load_o), 32'h0);

        // Line 0 still pending: taken at the next boundary.
        instr_done_i = 1'b1; pc_i = 10'h100;
        cyc();
        chk("pend0_vec", 32'(pc_load_val_o), 32'h3F0);
        chk("pend0_ack", 32'(irq_ack_o), 32'h1);
        irq_i = 4'b0000;
        instr_done_i = 1'b0;
        cyc();
        instr_done_i = 1'b1; reti_i = 1'b1;
        cyc();
        chk("pend0_ret_val", 32'(pc_load_val_o), 32'h100);
        chk("pend0_ret_c",   32'(intc_o), 32'h0);
        chk("pend0_ret_z",   32'(intz_o), 32'h1);
        instr_done_i = 1'b0; reti_i = 1'b0;
        cyc();

        irq_i = 4'b1010; irq_mask_i = 4'b1000; instr_done_i = 1'b1;
        cyc();
        chk("mask_vec", 32'(pc_load_val_o), 32'h3F3);
        chk("mask_ack", 32'(irq_ack_o), 32'h8);
        finish_isr();

        irq_mask_i = 4'b1010; instr_done_i = 1'b1;
        cyc();
        chk("prio_vec", 32'(pc_load_val_o), 32'h3F1);
        chk("prio_ack", 32'(irq_ack_o), 32'h2);
        irq_i = 4'b0000;
        finish_isr();

        // Request absent at the boundary edge is not taken.
        irq_mask_i = 4'hF; instr_done_i = 1'b1;
        cyc();
        chk("dropped_no_vec", 32'(pc_load_o), 32'h0);

        irq_i = 4'b0001;
        cyc();
        chk("stall_entry", 32'(pc_load_o), 32'h1);
        instr_done_i = 1'b0; clock_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc_load", 32'(pc_load_o), 32'h1);
            chk("stall_ack",     32'(irq_ack_o), 32'h1);
        end
        clock_en = 1'b1;
        cyc();
        chk("stall_done_pc_load", 32'(pc_load_o), 32'h0);
        chk("stall_done_ack",     32'(irq_ack_o), 32'h0);
        chk("stall_done_in_isr",  32'(in_isr_o), 32'h1);
        irq_i = 4'b0000;
        instr_done_i = 1'b1; reti_i = 1'b1;
        cyc();
        instr_done_i = 1'b0; reti_i = 1'b0;
        cyc();

        // RETI while idle does nothing.
        instr_done_i = 1'b1; reti_i = 1'b1;
        cyc();
        chk("idle_reti_pc_load", 32'(pc_load_o), 32'h0);
        chk("idle_reti_iwe",     32'(iwe_o), 32'h0);
        reti_i = 1'b0;

        irq_i = 4'b0010;
        cyc();
        chk("pre_rst_vec", 32'(pc_load_val_o), 32'h3F1);
        instr_done_i = 1'b0; irq_i = 4'b0000;
        cyc();
        chk("pre_rst_in_isr", 32'(in_isr_o), 32'h1);
        rst = 1'b0;
        #2;
        chk("mid_rst_in_isr",  32'(in_isr_o), 32'h0);
        chk("mid_rst_pc_load", 32'(pc_load_o), 32'h0);
        chk("mid_rst_gie",     32'(gie_o), 32'h0);
        rst = 1'b1;
        instr_done_i = 1'b1; reti_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("mid_rst_no_iwe",     32'(iwe_o), 32'h0);
            chk("mid_rst_no_pc_load", 32'(pc_load_o), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_flag_ctrl.md
# irq_flag_ctrl

Interrupt controller that sits directly upstream of the carry/zero flag register. At an instruction boundary it accepts a pending maskable interrupt, shadows the return PC and the C/Z flags, and redirects the PC to a vector. On RETI it redirects the PC back to the saved address. In the same cycle it drives the flag register's interrupt write port (`iwe`, `intc_i`, `intz_i`) to restore the saved flags.

## Interface
- `PC_W`, 10, program counter width
- `N_IRQ`, 4, number of interrupt request lines
- `VEC_BASE`, 10'h3F0, vector of line k is `VEC_BASE + k` (modulo 2^PC_W)

- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `clock_en`  in  1  global advance enable; when 0, all registers hold
- `irq_i`  in  N_IRQ  level-sensitive interrupt requests
- `irq_mask_i`  in  N_IRQ  per-line enable (1 = enabled)
- `gie_we_i`  in  1  EI/DI executed this cycle
- `gie_i`  in  1  value written to GIE when `gie_we_i`
- `instr_done_i`  in  1  current instruction completes this cycle
- `reti_i`  in  1  completing instruction is RETI (qualified by `instr_done_i`)
- `pc_i`  in  PC_W  address of next sequential instruction
- `c_i`, `z_i`  in  1 each  current flag register outputs
- `pc_load_o`  out  1  force PC to `pc_load_val_o`
- `pc_load_val_o`  out  PC_W  vector or return address
- `iwe_o`  out  1  interrupt write enable to the flag register
- `intc_o`, `intz_o`  out  1 each  restored flags
- `irq_ack_o`  out  N_IRQ  one-hot acknowledge pulse
- `in_isr_o`  out  1  controller is servicing an interrupt
- `gie_o`  out  1  global interrupt enable

## Operation
- Registers:
  - `state`, `gie`
  - `idx` (log2 N_IRQ bits)
  - `sh_pc`, `sh_c`, `sh_z`
- `pend = irq_i & irq_mask_i`. Priority is fixed: lowest index wins.
- States are IDLE, VECTOR, ISR and RESTORE. Every transition requires `clock_en=1`.
- IDLE:
  - Condition: `instr_done_i && gie && |pend`.
  - Action: capture `pc_i`→`sh_pc`, `c_i`→`sh_c`, `z_i`→`sh_z`, and the winning index→`idx`.
  - Next state: VECTOR.
  - `reti_i` in IDLE is ignored: no PC load and no flag write.
- VECTOR:
  - Outputs: `pc_load_o=1`, `pc_load_val_o=VEC_BASE+idx`, `irq_ack_o[idx]=1`.
  - Clear `gie`. Next state: ISR.
- ISR:
  - `in_isr_o=1`. New requests stay pending; there is no nesting.
  - On `instr_done_i && reti_i`: next state RESTORE.
- RESTORE:
  - Outputs: `pc_load_o=1`, `pc_load_val_o=sh_pc`, `iwe_o=1`, `intc_o=sh_c`, `intz_o=sh_z`.
  - Set `gie=1`. Next state: IDLE.
- GIE:
  - `gie_we_i` writes `gie` in any state, except that VECTOR's clear and RESTORE's set take precedence.
  - Request evaluation uses the registered `gie` (pre-edge value).
- All outputs are decoded from `state`, `idx` and the shadows. They are 0 in every state other than the one listed above.

## Timing
- Reset (`rst=0`, asynchronous):
  - `state`=IDLE; `gie`, `idx`, `sh_*` = 0.
  - All outputs = 0.
- Latency:
  - Accepting boundary edge → VECTOR outputs for exactly one `clock_en` cycle.
  - RETI boundary edge → RESTORE outputs for exactly one `clock_en` cycle.
- `clock_en=0` in VECTOR or RESTORE: outputs stay asserted and the state holds. Consumers are gated by the same `clock_en`, so each action is still applied exactly once.
- Request dropping:
  - A request dropped before the accepting edge is not taken.
  - A request dropped after the accepting edge is still vectored, using the latched `idx`.
- Simultaneous events:
  - `gie_we_i=1, gie_i=1` on the same edge as a request: not taken this edge (old `gie`=0).
  - `gie_we_i=1, gie_i=0` on the same edge as a request with `gie`=1: taken.
- Reset mid-operation (VECTOR, ISR or RESTORE) returns to IDLE with nothing restored.

## Structure
- Package `leonel_irq_pkg`:
  - `irq_state_t` enum (IDLE, VECTOR, ISR, RESTORE)
  - default `PC_W`, `N_IRQ`, `VEC_BASE` constants
- Sub-module `irq_prio_enc`: combinational lowest-index-first encoder producing `{valid, idx}` from `pend`.

## Test plan
- Reset: hold `rst=0` with `irq_i=4'b1111` → all outputs 0. After release, `gie_o=0`, and no vector until EI.
- Basic entry and exit:
  - Setup: EI, `irq_mask_i=4'hF`, `irq_i=4'b0100`, `pc_i=10'h025`, `c_i=1`, `z_i=0` at a boundary.
  - Entry: next cycle `pc_load_val_o=10'h3F2`, `irq_ack_o=4'b0100`, then `in_isr_o=1`.
  - Exit: RETI → `pc_load_val_o=10'h025`, `iwe_o=1`, `intc_o=1`, `intz_o=0`, `gie_o=1`.
- Priority and masking: `irq_i=4'b1010`, `irq_mask_i=4'b1000` → vector `10'h3F3`. With the mask opened to `4'b1010` → vector `10'h3F1`.
- No nesting: `irq_i[0]` raised during ISR → no PC load until RESTORE completes. One boundary later in IDLE → vector `10'h3F0`.
- Stall: `clock_en=0` for 3 cycles during VECTOR → `pc_load_o` is held high. Exactly one ISR entry occurs, with a single `irq_ack_o` pulse.
- Edge cases:
  - RETI in IDLE → no `pc_load_o` and no `iwe_o`.
  - Reset asserted in ISR → IDLE, and `iwe_o` is never pulsed.
